dmem_ctrl: RTL and testbench

//  Parametrised successor to the single-cycle data memory. Byte-addressed, little-endian RAM with a

---
 rtl/dmem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data RAM behind a valid/ready request/response handshake; response 1+WAIT_STATES cycles after acceptance.
// req_ready only in IDLE; the response is held until rsp_ready. `DMEM_OOR_ERR_EN faults addresses with bits set above ADDR_BITS.
module dmem_ctrl #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int RB = ADDR_BITS - 2;
  localparam int ROWS = 2 ** RB;
  localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [7:0]  mem [4][ROWS];

  logic [RB-1:0] row;
  logic [1:0]    lane;
  logic          acc_err;
  logic          wr_en;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rword;
  logic [31:0]   rshift;
  logic [31:0]   ldata;

  assign row  = addr_q[ADDR_BITS-1:2];
  assign lane = addr_q[1:0];

  always_comb begin
    acc_err = 1'b0;
    case (size_q)
      2'b01:   acc_err = addr_q[0];
      2'b10:   acc_err = |addr_q[1:0];
      2'b11:   acc_err = 1'b1;
      default: acc_err = 1'b0;
    endcase
`ifdef DMEM_OOR_ERR_EN
    if (|addr_q[31:ADDR_BITS]) acc_err = 1'b1;
`endif
  end

`ifndef DMEM_OOR_ERR_EN
  // Upper address bits alias by wrap in this build.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:ADDR_BITS];
`endif

  always_comb begin
    be    = 4'b0000;
    wlane = 32'h0;
    case (size_q)
      2'b00: begin
        be[lane] = 1'b1;
        wlane    = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be[{addr_q[1], 1'b0}] = 1'b1;
        be[{addr_q[1], 1'b1}] = 1'b1;
        wlane = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
      default: begin
        be    = 4'b0000;
        wlane = 32'h0;
      end
    endcase
  end

  assign wr_en = (state == S_ACCESS) && we_q && !acc_err && !rst;

  always_comb begin
    for (int i = 0; i < 4; i++) rword[8*i +: 8] = mem[i][row];
    rshift = rword >> {lane, 3'b000};
    case (size_q)
      2'b00:   ldata = uns_q ? {24'h0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   ldata = uns_q ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: ldata = rword;
    endcase
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !rst;
        if (req_valid) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT:   if (wait_cnt == 4'd0) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid) wait_cnt <= WS_INIT;
      else if (state == S_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      if (state == S_ACCESS) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (we_q || acc_err) ? 32'h0 : ldata;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Request registers and RAM carry no reset; they only matter once a request is accepted.
  always_ff @(posedge clk) begin
    if (!rst && state == S_IDLE && req_valid) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[i][row] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: instance 0 runs with no wait states, instance 1 with three.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_err;
  logic [1:0][31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  dmem_ctrl #(.ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_ctrl #(.ADDR_BITS(12), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // One complete transaction on instance s; lat counts edges from acceptance to rsp_valid.
  task automatic access(input int s, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid[s] = 1'b1;
    n = 0;
    while (!req_ready[s] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    lat = 0;
    while (!rsp_valid[s] && lat < 100) begin @(posedge clk); #1; lat++; end
    rdata = rsp_rdata[s];
    err   = rsp_err[s];
    rsp_ready[s] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_data: got %h/%b expected 00000000/0", rsp_rdata[0], rsp_err[0]); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b11) begin errors++; $display("FAIL reset_release_ready: got %b expected 11", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sw_latency: got %0d expected 1", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_rsp: got %h/%b expected 00000000/0", rd, er); end
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL lw_latency: got %0d expected 1", lat); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_data: got %h/%b expected deadbeef/0", rd, er); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, rd, er, lat);
    access(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin errors++; $display("FAIL lb_sext: got %h/%b expected ffffff80/0", rd, er); end
    access(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h expected 00000080", rd); end
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_after_sb: got %h expected 80adbeef", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h55557777, rd, er, lat);
    access(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hAAAA8001, rd, er, lat);
    access(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF8001 || er !== 1'b0) begin errors++; $display("FAIL lh_sext: got %h/%b expected ffff8001/0", rd, er); end
    access(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_zext: got %h expected 00008001", rd); end
    access(0, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL lh_misaligned: got %h/%b expected 00000000/1", rd, er); end
    access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80017777) begin errors++; $display("FAIL lw_after_sh: got %h expected 80017777", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h11111111, rd, er, lat);
    access(0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h22222222, rd, er, lat);
    access(0, 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, rd, er, lat);
    checks++; if (rd !== 32'h0 || er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL sw_misaligned: got %h/%b lat %0d expected 00000000/1 lat 1", rd, er, lat); end
    access(0, 1'b1, 2'b01, 1'b0, 32'h05, 32'hFFFFFFFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh_misaligned: got err %b expected 1", er); end
    access(0, 1'b1, 2'b11, 1'b0, 32'h04, 32'h99999999, rd, er, lat);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL store_size11: got %h/%b expected 00000000/1", rd, er); end
    access(0, 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL load_size11: got %h/%b expected 00000000/1", rd, er); end
    access(0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h11111111 || er !== 1'b0) begin errors++; $display("FAIL unchanged_04: got %h/%b expected 11111111/0", rd, er); end
    access(0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h22222222 || er !== 1'b0) begin errors++; $display("FAIL unchanged_08: got %h/%b expected 22222222/0", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 4; i++)
      access(0, 1'b1, 2'b00, 1'b0, 32'h50 + 32'(i), 32'hFFFFFF00 | 32'(i + 1), rd, er, lat);
    access(0, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h04030201) begin errors++; $display("FAIL b2b_lw: got %h expected 04030201", rd); end
    access(0, 1'b0, 2'b01, 1'b1, 32'h52, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000403) begin errors++; $display("FAIL b2b_lhu: got %h expected 00000403", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat; int n;
    access(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A55A5A, rd, er, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws_sw_latency: got %0d expected 4", lat); end
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h30; req_wdata = 32'h0;
    req_valid[1] = 1'b1;
    n = 0;
    while (!req_ready[1] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    lat = 0;
    while (!rsp_valid[1] && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws_lw_latency: got %0d expected 4", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hA5A55A5A || req_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL ws_stall_%0d: got valid %b data %h ready %b expected 1 a5a55a5a 0", i, rsp_valid[1], rsp_rdata[1], req_ready[1]);
      end
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;
    checks++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || rsp_rdata[1] !== 32'hA5A55A5A) begin
      errors++;
      $display("FAIL ws_after_hs: got valid %b ready %b data %h expected 0 1 a5a55a5a", rsp_valid[1], req_ready[1], rsp_rdata[1]);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b0, 2'b10, 1'b0, 32'h00001010, 32'h0, rd, er, lat);
`ifdef DMEM_OOR_ERR_EN
    checks++; if (rd !== 32'h0 || er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL oor_fault: got %h/%b lat %0d expected 00000000/1 lat 1", rd, er, lat); end
`else
    checks++; if (rd !== 32'h80ADBEEF || er !== 1'b0 || lat !== 1) begin errors++; $display("FAIL alias_wrap: got %h/%b lat %0d expected 80adbeef/0 lat 1", rd, er, lat); end
`endif
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; int n;
    access(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, rd, er, lat);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    req_valid[1] = 1'b1;
    n = 0;
    while (!req_ready[1] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin errors++; $display("FAIL abort_in_reset: got valid %b ready %b expected 0 0", rsp_valid[1], req_ready[1]); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL abort_no_rsp: got valid %b expected 0", rsp_valid[1]); end
    access(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h12345678 || er !== 1'b0 || lat !== 4) begin errors++; $display("FAIL abort_store_dropped: got %h/%b lat %0d expected 12345678/0 lat 4", rd, er, lat); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_wait_states();
    test_alias();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
